// File: rtl/am_query_scheduler.sv
// am_query_scheduler: round-robin arbiter sharing one associative memory among
// NUM_REQ query sources; a watchdog abandons slow queries and drains their late results.
`timescale 1ns/1ps
`ifndef HV_DIMENSION
`define HV_DIMENSION 64
`endif
`ifndef LABEL_WIDTH
`define LABEL_WIDTH 4
`endif
`ifndef DISTANCE_WIDTH
`define DISTANCE_WIDTH 10
`endif

module am_query_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int REQ_ID_WIDTH   = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                               Clk_CI,
    input  logic                               Reset_RI,
    input  logic [NUM_REQ-1:0]                 ReqValid_SI,
    output logic [NUM_REQ-1:0]                 ReqReady_SO,
    input  logic [NUM_REQ*`HV_DIMENSION-1:0]   ReqHypervector_DI,
    output logic [NUM_REQ-1:0]                 RespValid_SO,
    input  logic [NUM_REQ-1:0]                 RespReady_SI,
    output logic [`LABEL_WIDTH-1:0]            RespLabel_A_DO,
    output logic [`LABEL_WIDTH-1:0]            RespLabel_V_DO,
    output logic [`DISTANCE_WIDTH-1:0]         RespDistance_A_DO,
    output logic [`DISTANCE_WIDTH-1:0]         RespDistance_V_DO,
    output logic                               RespTimeout_SO,
    output logic                               AmValid_SO,
    input  logic                               AmReady_SI,
    output logic [`HV_DIMENSION-1:0]           AmHypervector_DO,
    input  logic                               AmValid_SI,
    output logic                               AmReady_SO,
    input  logic [`LABEL_WIDTH-1:0]            AmLabel_A_DI,
    input  logic [`LABEL_WIDTH-1:0]            AmLabel_V_DI,
    input  logic [`DISTANCE_WIDTH-1:0]         AmDistance_A_DI,
    input  logic [`DISTANCE_WIDTH-1:0]         AmDistance_V_DI,
    output logic [REQ_ID_WIDTH-1:0]            Grant_DO,
    output logic                               Busy_SO
);
    localparam int HV = `HV_DIMENSION;
    localparam int LW = `LABEL_WIDTH;
    localparam int DW = `DISTANCE_WIDTH;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RESPOND = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [REQ_ID_WIDTH-1:0] ptr_q, ptr_d, grant_q, grant_d;
    logic                    pending_q, pending_d, timeout_q, timeout_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [HV-1:0]           query_q, query_d;
    logic [LW-1:0]           lab_a_q, lab_a_d, lab_v_q, lab_v_d;
    logic [DW-1:0]           dst_a_q, dst_a_d, dst_v_q, dst_v_d;

    logic [HV-1:0]           req_hv [NUM_REQ];
    logic                    gnt_found, grant_ok;
    logic [REQ_ID_WIDTH-1:0] gnt_idx, cand;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign req_hv[i] = ReqHypervector_DI[i*HV +: HV];
    end

    // Scan from the requester after the last served one, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = REQ_ID_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
            if (!gnt_found && ReqValid_SI[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign grant_ok = (state_q == ST_IDLE) && !pending_q && gnt_found && !Reset_RI;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        pending_d = pending_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        query_d   = query_q;
        lab_a_d   = lab_a_q;
        lab_v_d   = lab_v_q;
        dst_a_d   = dst_a_q;
        dst_v_d   = dst_v_q;
        // A late result from an abandoned query is swallowed in any state.
        if (pending_q && AmValid_SI) pending_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_ok) begin
                    query_d = req_hv[gnt_idx];
                    grant_d = gnt_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (AmReady_SI) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (AmValid_SI) begin
                    lab_a_d   = AmLabel_A_DI;
                    lab_v_d   = AmLabel_V_DI;
                    dst_a_d   = AmDistance_A_DI;
                    dst_v_d   = AmDistance_V_DI;
                    timeout_d = 1'b0;
                    state_d   = ST_RESPOND;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    pending_d = 1'b1;
                    lab_a_d   = '0;
                    lab_v_d   = '0;
                    dst_a_d   = '0;
                    dst_v_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_RESPOND;
                end
            end
            default: begin
                if (RespReady_SI[grant_q]) begin
                    ptr_d   = grant_q;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            state_q   <= ST_IDLE;
            ptr_q     <= REQ_ID_WIDTH'(NUM_REQ - 1);
            grant_q   <= '0;
            pending_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            query_q   <= '0;
            lab_a_q   <= '0;
            lab_v_q   <= '0;
            dst_a_q   <= '0;
            dst_v_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            pending_q <= pending_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            query_q   <= query_d;
            lab_a_q   <= lab_a_d;
            lab_v_q   <= lab_v_d;
            dst_a_q   <= dst_a_d;
            dst_v_q   <= dst_v_d;
        end
    end

    assign ReqReady_SO       = grant_ok ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign RespValid_SO      = (state_q == ST_RESPOND) ? (NUM_REQ'(1) << grant_q) : '0;
    assign RespLabel_A_DO    = lab_a_q;
    assign RespLabel_V_DO    = lab_v_q;
    assign RespDistance_A_DO = dst_a_q;
    assign RespDistance_V_DO = dst_v_q;
    assign RespTimeout_SO    = timeout_q;
    assign AmValid_SO        = (state_q == ST_ISSUE);
    assign AmHypervector_DO  = query_q;
    assign AmReady_SO        = (state_q == ST_WAIT) | pending_q;
    assign Grant_DO          = grant_q;
    assign Busy_SO           = (state_q != ST_IDLE) | pending_q;

endmodule

// File: tb/tb_am_query_scheduler.sv
// Scoreboard bench for am_query_scheduler: randomized requests, a stand-in AM with
// chosen latencies, and a round-robin reference model predicting every response.
`timescale 1ns/1ps
`ifndef HV_DIMENSION
`define HV_DIMENSION 64
`endif
`ifndef LABEL_WIDTH
`define LABEL_WIDTH 4
`endif
`ifndef DISTANCE_WIDTH
`define DISTANCE_WIDTH 10
`endif

module tb_am_query_scheduler;
    localparam int NR = 4;
    localparam int T  = 24;
    localparam int HV = `HV_DIMENSION;
    localparam int LW = `LABEL_WIDTH;
    localparam int DW = `DISTANCE_WIDTH;

    logic                 Clk_CI = 1'b0;
    logic                 Reset_RI;
    logic [NR-1:0]        ReqValid_SI, ReqReady_SO, RespValid_SO, RespReady_SI;
    logic [NR*HV-1:0]     ReqHypervector_DI;
    logic [LW-1:0]        RespLabel_A_DO, RespLabel_V_DO, AmLabel_A_DI, AmLabel_V_DI;
    logic [DW-1:0]        RespDistance_A_DO, RespDistance_V_DO, AmDistance_A_DI, AmDistance_V_DI;
    logic                 RespTimeout_SO, AmValid_SO, AmReady_SI, AmValid_SI, AmReady_SO, Busy_SO;
    logic [HV-1:0]        AmHypervector_DO;
    logic [1:0]           Grant_DO;

    am_query_scheduler #(.NUM_REQ(NR), .REQ_ID_WIDTH(2), .TIMEOUT_CYCLES(T)) dut (
        .Clk_CI(Clk_CI), .Reset_RI(Reset_RI),
        .ReqValid_SI(ReqValid_SI), .ReqReady_SO(ReqReady_SO), .ReqHypervector_DI(ReqHypervector_DI),
        .RespValid_SO(RespValid_SO), .RespReady_SI(RespReady_SI),
        .RespLabel_A_DO(RespLabel_A_DO), .RespLabel_V_DO(RespLabel_V_DO),
        .RespDistance_A_DO(RespDistance_A_DO), .RespDistance_V_DO(RespDistance_V_DO),
        .RespTimeout_SO(RespTimeout_SO),
        .AmValid_SO(AmValid_SO), .AmReady_SI(AmReady_SI), .AmHypervector_DO(AmHypervector_DO),
        .AmValid_SI(AmValid_SI), .AmReady_SO(AmReady_SO),
        .AmLabel_A_DI(AmLabel_A_DI), .AmLabel_V_DI(AmLabel_V_DI),
        .AmDistance_A_DI(AmDistance_A_DI), .AmDistance_V_DI(AmDistance_V_DI),
        .Grant_DO(Grant_DO), .Busy_SO(Busy_SO)
    );

    always #5 Clk_CI = ~Clk_CI;

    typedef struct {
        int          who;
        logic [LW-1:0] la, lv;
        logic [DW-1:0] da, dv;
        logic        to;
        int          lat;
    } exp_t;

    exp_t          exp_q[$];
    int            n_vec = 0, n_err = 0, cyc = 0, resp_done = 0;
    int            ref_ptr = NR - 1, am_lat = 1, am_hs_cyc = 0;
    logic          drain_exp = 1'b0;
    logic [HV-1:0] hv_tb [NR];

    always @(posedge Clk_CI) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [HV-1:0] act, input logic [HV-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    task automatic abort_run(input string nm);
        chk(nm, 64'd0, 64'd1);
        finish_run();
    endtask

    // The AM's answer is a fixed slicing of the query it received.
    task automatic am_answer(input logic [HV-1:0] h, output logic [LW-1:0] la, output logic [LW-1:0] lv,
                             output logic [DW-1:0] da, output logic [DW-1:0] dv);
        la = h[LW-1:0];
        lv = h[2*LW-1:LW];
        da = h[2*LW +: DW];
        dv = h[2*LW+DW +: DW];
    endtask

    task automatic rand_hv();
        for (int i = 0; i < NR; i++) hv_tb[i] = {$urandom, $urandom};
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, HV'(ReqReady_SO), '0);
        chk({tag, "_resp_valid"}, HV'(RespValid_SO), '0);
        chk({tag, "_am_valid"}, HV'(AmValid_SO), '0);
        chk({tag, "_am_ready"}, HV'(AmReady_SO), '0);
        chk({tag, "_am_hv"}, AmHypervector_DO, '0);
        chk({tag, "_fields"}, HV'({RespLabel_A_DO, RespLabel_V_DO, RespDistance_A_DO, RespDistance_V_DO, RespTimeout_SO}), '0);
        chk({tag, "_grant"}, HV'(Grant_DO), '0);
        chk({tag, "_busy"}, HV'(Busy_SO), '0);
    endtask

    // One query: predict winner and response, present the request, verify the grant.
    task automatic do_tx(input logic [NR-1:0] mask, input int lat);
        exp_t e;
        int   who, target;
        bit   got;
        who = -1;
        for (int k = 1; k <= NR; k++)
            if (who < 0 && mask[(ref_ptr + k) % NR]) who = (ref_ptr + k) % NR;
        e.who = who;
        if (lat <= T) begin
            am_answer(hv_tb[who], e.la, e.lv, e.da, e.dv);
            e.to  = 1'b0;
            e.lat = lat + 1;
        end else begin
            e.la = '0; e.lv = '0; e.da = '0; e.dv = '0;
            e.to  = 1'b1;
            e.lat = T + 1;
        end
        exp_q.push_back(e);
        target = resp_done + 1;
        @(posedge Clk_CI); #1;
        for (int i = 0; i < NR; i++) ReqHypervector_DI[i*HV +: HV] = hv_tb[i];
        am_lat      = lat;
        ReqValid_SI = mask;
        got = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge Clk_CI);
            if (drain_exp) chk("grant_during_drain", HV'(ReqReady_SO), '0);
            if (ReqReady_SO != '0) got = 1'b1;
        end
        if (!got) abort_run("req_accept_bound");
        chk("req_ready", HV'(ReqReady_SO), HV'(NR'(1) << who));
        @(posedge Clk_CI); #1;
        ReqValid_SI = '0;
        ReqHypervector_DI = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        @(negedge Clk_CI);
        chk("am_valid_rise", HV'(AmValid_SO), HV'(1));
        chk("am_hv", AmHypervector_DO, hv_tb[who]);
        chk("grant_idx", HV'(Grant_DO), HV'(who));
        for (int n = 0; n < 400 && resp_done < target; n++) @(negedge Clk_CI);
        if (resp_done < target) abort_run("resp_bound");
        ref_ptr = who;
    endtask

    // Stand-in associative memory: answers after am_lat cycles, one query at a time.
    initial begin : am_model
        logic          s_in, s_out, s_rst, busy;
        logic [HV-1:0] s_hv, a_hv;
        int            s_cyc, cnt;
        AmValid_SI = 1'b0; AmReady_SI = 1'b0;
        AmLabel_A_DI = '0; AmLabel_V_DI = '0; AmDistance_A_DI = '0; AmDistance_V_DI = '0;
        busy = 1'b0; cnt = 0; a_hv = '0;
        forever begin
            @(negedge Clk_CI);
            s_in  = AmValid_SO && AmReady_SI;
            s_out = AmValid_SI && AmReady_SO;
            s_rst = Reset_RI;
            s_hv  = AmHypervector_DO;
            s_cyc = cyc;
            @(posedge Clk_CI); #1;
            if (s_rst || Reset_RI) begin
                busy = 1'b0; AmValid_SI = 1'b0; AmReady_SI = 1'b0;
                continue;
            end
            if (s_out) begin
                AmValid_SI = 1'b0;
                busy       = 1'b0;
                drain_exp  = 1'b0;
            end
            if (s_in) begin
                busy = 1'b1; cnt = am_lat; a_hv = s_hv; am_hs_cyc = s_cyc;
            end
            if (busy && !AmValid_SI) begin
                cnt--;
                if (cnt <= 0) begin
                    AmValid_SI = 1'b1;
                    am_answer(a_hv, AmLabel_A_DI, AmLabel_V_DI, AmDistance_A_DI, AmDistance_V_DI);
                end
            end
            AmReady_SI = busy ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Response monitor: pops the scoreboard, applies backpressure, checks stability.
    initial begin : monitor
        exp_t          e;
        logic [NR-1:0] oh;
        logic [HV-1:0] snap;
        int            hold;
        RespReady_SI = '0;
        forever begin
            @(negedge Clk_CI);
            if (Reset_RI || RespValid_SO == '0) continue;
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", HV'(RespValid_SO), '0);
                @(posedge Clk_CI); #1 RespReady_SI = '1;
                @(posedge Clk_CI); #1 RespReady_SI = '0;
                continue;
            end
            e  = exp_q.pop_front();
            oh = NR'(1) << e.who;
            chk("resp_valid", HV'(RespValid_SO), HV'(oh));
            chk("resp_grant", HV'(Grant_DO), HV'(e.who));
            chk("resp_label_a", HV'(RespLabel_A_DO), HV'(e.la));
            chk("resp_label_v", HV'(RespLabel_V_DO), HV'(e.lv));
            chk("resp_dist_a", HV'(RespDistance_A_DO), HV'(e.da));
            chk("resp_dist_v", HV'(RespDistance_V_DO), HV'(e.dv));
            chk("resp_timeout", HV'(RespTimeout_SO), HV'(e.to));
            chk("resp_latency", HV'(cyc - am_hs_cyc), HV'(e.lat));
            if (e.to) drain_exp = 1'b1;
            snap = HV'({RespLabel_A_DO, RespLabel_V_DO, RespDistance_A_DO, RespDistance_V_DO, RespTimeout_SO});
            hold = ($urandom_range(0, 3) == 0) ? 10 : $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                @(posedge Clk_CI); #1;
                RespReady_SI = NR'($urandom) & ~oh;
                @(negedge Clk_CI);
                chk("hold_valid", HV'(RespValid_SO), HV'(oh));
                chk("hold_fields", HV'({RespLabel_A_DO, RespLabel_V_DO, RespDistance_A_DO, RespDistance_V_DO, RespTimeout_SO}), snap);
                chk("hold_no_am_valid", HV'(AmValid_SO), '0);
            end
            @(posedge Clk_CI); #1 RespReady_SI = oh | NR'($urandom);
            @(posedge Clk_CI); #1 RespReady_SI = '0;
            @(negedge Clk_CI);
            chk("resp_released", HV'(RespValid_SO), '0);
            chk("idle_busy", HV'(Busy_SO), HV'(drain_exp));
            resp_done++;
        end
    end

    initial begin : watchdog
        #500000;
        abort_run("global_time_bound");
    end

    initial begin : driver
        int            got;
        logic [HV-1:0] h;
        Reset_RI = 1'b1;
        ReqValid_SI = '1;
        ReqHypervector_DI = '1;
        for (int i = 0; i < NR; i++) hv_tb[i] = '0;
        repeat (3) @(posedge Clk_CI);
        @(negedge Clk_CI);
        check_reset_outputs("reset");
        @(posedge Clk_CI); #1;
        ReqValid_SI = '0;
        Reset_RI = 1'b0;

        repeat (6) begin
            rand_hv();
            do_tx(4'b1111, $urandom_range(1, T - 1));
        end

        rand_hv();
        h = hv_tb[2];
        h[LW-1:0] = LW'(1);
        h[2*LW +: DW] = DW'(37);
        hv_tb[2] = h;
        do_tx(4'b0100, 20);

        rand_hv();
        do_tx(NR'(1) << $urandom_range(0, NR - 1), T + 12);
        rand_hv();
        do_tx(4'b1111, 4);

        rand_hv();
        do_tx(NR'(1) << $urandom_range(0, NR - 1), T);

        repeat (40) begin
            int mode, lat;
            rand_hv();
            mode = $urandom_range(0, 9);
            if (mode < 2) lat = $urandom_range(T + 1, T + 8);
            else if (mode == 2) lat = T;
            else lat = $urandom_range(1, T - 1);
            do_tx(NR'($urandom_range(1, 15)), lat);
        end

        // Reset while a query sits in WAIT.
        rand_hv();
        @(posedge Clk_CI); #1;
        for (int i = 0; i < NR; i++) ReqHypervector_DI[i*HV +: HV] = hv_tb[i];
        am_lat = 5000;
        ReqValid_SI = 4'b0010;
        got = 0;
        for (int n = 0; n < 100 && got == 0; n++) begin
            @(negedge Clk_CI);
            if (ReqReady_SO != '0) got = 1;
        end
        if (got == 0) abort_run("rst_req_bound");
        @(posedge Clk_CI); #1 ReqValid_SI = '0;
        got = 0;
        for (int n = 0; n < 100 && got == 0; n++) begin
            @(negedge Clk_CI);
            if (AmReady_SO) got = 1;
        end
        if (got == 0) abort_run("rst_wait_bound");
        repeat (3) @(posedge Clk_CI);
        #2;
        ReqValid_SI = '1;
        Reset_RI = 1'b1;
        #1;
        check_reset_outputs("midwait_reset");
        @(posedge Clk_CI); #1;
        ReqValid_SI = '0;
        @(posedge Clk_CI); #1;
        Reset_RI  = 1'b0;
        ref_ptr   = NR - 1;
        drain_exp = 1'b0;
        rand_hv();
        do_tx(4'b1111, 3);

        repeat (4) @(posedge Clk_CI);
        chk("scoreboard_empty", HV'(exp_q.size()), '0);
        finish_run();
    end

endmodule

// File: doc/am_query_scheduler.md
# am_query_scheduler

Round-robin scheduler that shares one associative_memory instance among `NUM_REQ` query sources (per-window encoder outputs). It grants one requester at a time and forwards that requester's query hypervector over the AM input handshake. It collects the arousal/valence label and distance result, then returns it to the owning requester. A watchdog bounds how long a requester waits on the AM and drains any late result so the AM never stalls.

## Interface
Parameters:
- `NUM_REQ`, 4: number of query sources; 2..8.
- `REQ_ID_WIDTH`, 2: width of the requester index; ceilLog2(`NUM_REQ`), minimum 1.
- `TIMEOUT_CYCLES`, 1023: maximum cycles spent in WAIT before the query is abandoned; 1..65535.

Ports. Widths use the `HV_DIMENSION`, `LABEL_WIDTH` and `DISTANCE_WIDTH` macros from const.vh.
- `Clk_CI`  in  1  clock; single clock domain.
- `Reset_RI`  in  1  asynchronous, active-high reset.
- `ReqValid_SI`  in  `NUM_REQ`  per-requester query valid.
- `ReqReady_SO`  out  `NUM_REQ`  per-requester query accept; one-hot or zero.
- `ReqHypervector_DI`  in  `NUM_REQ`*`HV_DIMENSION`  query of requester i is slice [i*`HV_DIMENSION` +: `HV_DIMENSION`].
- `RespValid_SO`  out  `NUM_REQ`  per-requester result valid; one-hot or zero.
- `RespReady_SI`  in  `NUM_REQ`  per-requester result accept.
- `RespLabel_A_DO`, `RespLabel_V_DO`  out  `LABEL_WIDTH`  shared result labels, qualified by `RespValid_SO`.
- `RespDistance_A_DO`, `RespDistance_V_DO`  out  `DISTANCE_WIDTH`  shared result distances.
- `RespTimeout_SO`  out  1  result is a timeout, not an AM result.
- `AmValid_SO`  out  1  query valid to the AM (drives AM `ValidIn_SI`).
- `AmReady_SI`  in  1  AM `ReadyOut_SO`.
- `AmHypervector_DO`  out  `HV_DIMENSION`  query to the AM.
- `AmValid_SI`  in  1  AM `ValidOut_SO`.
- `AmReady_SO`  out  1  drives AM `ReadyIn_SI`.
- `AmLabel_A_DI`, `AmLabel_V_DI`  in  `LABEL_WIDTH`  AM label outputs.
- `AmDistance_A_DI`, `AmDistance_V_DI`  in  `DISTANCE_WIDTH`  AM distance outputs.
- `Grant_DO`  out  `REQ_ID_WIDTH`  index of the current or last owner.
- `Busy_SO`  out  1  state is not IDLE, or a drain is pending.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESPOND, plus a `Pending` flag for draining an abandoned AM result.
- **IDLE**
  - If any `ReqValid_SI` is high, grant the first valid index scanning from (`Ptr`+1) mod `NUM_REQ` upward, with wrap-around.
  - Assert `ReqReady_SO[g]` combinationally in that cycle.
  - Latch `ReqHypervector_DI` slice g into the query register, set `Grant_DO`=g and go to ISSUE.
  - If `Pending`=1, IDLE grants nothing; the previous query must drain first.
- **ISSUE**
  - `AmValid_SO`=1 and `AmHypervector_DO` holds the query register stable.
  - On `AmReady_SI`=1, clear the watchdog counter and go to WAIT.
- **WAIT**
  - `AmReady_SO`=1 and the watchdog counter increments every cycle.
  - On `AmValid_SI`=1, capture the four AM result fields, set `RespTimeout_SO`=0 and go to RESPOND.
  - Else, if the counter equals `TIMEOUT_CYCLES`-1, set `Pending`=1, zero the result fields, set `RespTimeout_SO`=1 and go to RESPOND.
  - If `AmValid_SI` and the timeout hit occur in the same cycle, the result wins.
- **RESPOND**
  - `RespValid_SO[g]`=1 and the result fields are held stable.
  - On `RespReady_SI[g]`=1, set `Ptr`=g and go to IDLE.
- **Drain:** `AmReady_SO` = (state==WAIT) | `Pending`. When `Pending`=1 and `AmValid_SI`=1, the result is discarded and `Pending` is cleared. Draining runs in any state.
- **Fairness:** `Ptr` advances only on a completed response, so a requester that stays valid is served at most once every `NUM_REQ` grants while the others are also requesting.
- **Width rules:** the result fields are pass-through copies with no arithmetic. The watchdog counter is ceilLog2(`TIMEOUT_CYCLES`+1) bits and never wraps.
- **Reset:**
  - Takes effect immediately, including mid-query.
  - Sets state=IDLE, `Ptr`=`NUM_REQ`-1 so that requester 0 has first priority, `Pending`=0, and zero for the query register, result fields, counter and `Grant_DO`.
  - All outputs go low or zero.
  - The AM shares the same reset, so no drain is needed after reset.

## Timing
- Request accept: `ReqReady_SO[g]` is high in the same cycle IDLE sees the valid, and the query is registered on that edge.
- `AmValid_SO` rises 1 cycle after the request handshake.
- The AM result is registered on the `AmValid_SI`&`AmReady_SO` edge. `RespValid_SO` rises the next cycle and holds until accepted.
- Minimum request-to-response latency is 2 + AM latency cycles.
- A new grant can occur the cycle after the response handshake; there is one IDLE cycle between queries.
- Timeout: `RespValid_SO` with `RespTimeout_SO`=1 appears exactly `TIMEOUT_CYCLES`+1 cycles after entry to WAIT.

## Test plan
- **Single query:** requester 2 valid alone; the AM returns label_A=1, dist_A=37 after 20 cycles → `ReqReady_SO`=4'b0100 in the same cycle, and `RespValid_SO`=4'b0100 with label 1 / distance 37, `RespTimeout_SO`=0.
- **Round robin:** all four valid continuously with `RespReady_SI` tied high → grant order 0,1,2,3,0,1, one response each.
- **Backpressure:** hold `RespReady_SI[1]` low for 10 cycles → fields stay stable, no new `AmValid_SO`; release → IDLE on the next edge.
- **Timeout:** `TIMEOUT_CYCLES`=8 and the AM never answers → timeout response 9 cycles after WAIT entry. A late AM answer is then drained, and the next grant is blocked until the drain completes.
- **Simultaneous events:** `AmValid_SI` arrives exactly on the timeout cycle → real result returned, `RespTimeout_SO`=0, `Pending`=0.
- **Reset mid-WAIT:** assert `Reset_RI` asynchronously → all outputs zero before the next edge; requester 0 is served first after release.
